rvsteel_gpio_input_irq: RTL and testbench
=========================================

// Module: rvsteel_gpio_input_irq
// PURPOSE
//  Conditions raw GPIO pad inputs before they reach rvsteel_gpio.gpio_input: 2-FF synchroniser,
//  per-pin debounce, edge detection and edge-triggered interrupt with pending latch.
//  Memory-mapped on the same 5-bit-address request/response bus as the GPIO block; one instance per GPIO bank.
// PARAMETERS
//  GPIO_WIDTH      1   number of pins (1..32)
//  DEBOUNCE_WIDTH  16  width of debounce-threshold register and per-pin counters (1..32)
// PORTS
//  clock           in   1                clock; only clock domain
//  reset           in   1                synchronous, active-high reset
//  rw_address      in   5                byte address within block
//  read_data       out  32               read data, valid with read_response
//  read_request    in   1                read strobe, one cycle
//  read_response   out  1                read acknowledge
//  write_data      in   32               write data
//  write_strobe    in   4                byte enables; only 4'b1111 writes
//  write_request   in   1                write strobe, one cycle
//  write_response  out  1                write acknowledge
//  pad_input       in   GPIO_WIDTH       raw asynchronous pad inputs
//  gpio_input      out  GPIO_WIDTH       debounced level; drives rvsteel_gpio.gpio_input
//  irq             out  1                OR of all PENDING bits
// BEHAVIOUR
//  Reset: read_data=0, read_response=0, write_response=0, sync FFs=0, stable=0, counters=0,
//   RISE_EN=FALL_EN=PENDING=0, DEBOUNCE=0 -> gpio_input=0, irq=0.
//  Registers (word offsets; address aligned iff rw_address[1:0]==0):
//   0x00 RISE_EN  rw  per-pin rising-edge interrupt enable
//   0x04 FALL_EN  rw  per-pin falling-edge interrupt enable
//   0x08 PENDING  r/w1c  latched edge events; write 1 clears bit
//   0x0C LEVEL    ro  debounced level (== gpio_input)
//   0x10 DEBOUNCE rw  threshold N, low DEBOUNCE_WIDTH bits used
//  Bus: read_response/write_response = request delayed 1 cycle, always (even unmapped/misaligned).
//   Read: aligned+mapped -> zero-extended register; unmapped or misaligned -> 0.
//   Write: effective only if aligned, mapped and write_strobe==4'b1111; else ignored. Writes to LEVEL ignored.
//  Synchroniser: sync = pad_input through 2 FFs (2-cycle latency).
//  Debounce per pin: if sync==stable: cnt<=0. Else if cnt>=N: stable<=sync, cnt<=0; else cnt<=cnt+1.
//   Hence stable follows a clean change N+1 cycles after sync changes; N=0 -> 1 cycle. Pad->gpio_input = N+3.
//   A glitch shorter than N+1 cycles is discarded (cnt clears). N written mid-count takes effect next cycle;
//   counter saturates at all-ones, never wraps.
//  Edge: rise = stable update 0->1, fall = 1->0, one-cycle pulse in the cycle stable changes.
//   PENDING[i] <= (PENDING[i] & ~clr[i]) | (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]).
//   Simultaneous set and W1C on same bit: set wins. Enable cleared does not clear PENDING.
//  irq = |PENDING (registered bits, no extra delay). Reset mid-debounce discards the count and any edge in flight.
// STRUCTURE
//  Shared package/header: register offset constants (REG_RISE_EN..REG_DEBOUNCE), register-address width.
//  Sub-module rvsteel_gpio_debounce: one pin's sync FFs + counter + stable + rise/fall pulses; generate GPIO_WIDTH copies.
//  Top: bus decode, enable/pending registers, read mux, irq OR.
// TESTING
//  1 Reset: after reset, read 0x00..0x10 -> all 0; gpio_input=0, irq=0.
//  2 DEBOUNCE=3, pad[0] 0->1 held -> gpio_input[0] rises exactly 6 cycles later; 3-cycle pulse -> no change.
//  3 RISE_EN=1, pad[0] rises -> PENDING=1, irq=1; write 0x08=1 -> PENDING=0, irq=0 next cycle.
//  4 FALL_EN=2 only, pin1 rises then falls -> PENDING=2 only after fall; rise sets nothing.
//  5 W1C on PENDING[0] in same cycle as new rise on pin0 -> PENDING[0] stays 1.
//  6 Write 0x00 with strobe 4'b0011, and to 0x01 -> RISE_EN unchanged; write_response still 1 cycle later;
//    read 0x14 -> 0.

Source files
------------

// File: rtl/rvsteel_gpio_input_irq_pkg.sv
// Shared definitions for the GPIO input conditioning / interrupt block:
// register map, bus address width and small bus-decode helpers.
package rvsteel_gpio_input_irq_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] REG_RISE_EN  = 5'h00;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_FALL_EN  = 5'h04;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_PENDING  = 5'h08;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_LEVEL    = 5'h0C;
  localparam logic [REG_ADDR_WIDTH-1:0] REG_DEBOUNCE = 5'h10;

  localparam logic [3:0] FULL_WORD_STROBE = 4'b1111;

  function automatic logic is_aligned(input logic [REG_ADDR_WIDTH-1:0] address);
    return address[1:0] == 2'b00;
  endfunction

  function automatic logic is_full_word(input logic [3:0] strobe);
    return strobe == FULL_WORD_STROBE;
  endfunction

endpackage

// File: rtl/rvsteel_gpio_debounce.sv
// One pad: two-flop synchroniser, threshold debounce counter and
// single-cycle rise/fall pulses marking the cycle the debounced level updates.
module rvsteel_gpio_debounce #(
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pad,
  input  logic [DEBOUNCE_WIDTH-1:0] threshold,
  output logic                      stable,
  output logic                      rise,
  output logic                      fall
);

  logic                      sync_meta;
  logic                      sync_out;
  logic [DEBOUNCE_WIDTH-1:0] count;
  logic                      update;

  // The level commits once the synchronised value has disagreed for threshold+1 edges.
  always_comb begin
    update = (sync_out != stable) && (count >= threshold);
    rise   = update & sync_out;
    fall   = update & ~sync_out;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
      stable    <= 1'b0;
      count     <= '0;
    end else begin
      sync_meta <= pad;
      sync_out  <= sync_meta;
      if (sync_out == stable) begin
        count <= '0;
      end else if (update) begin
        stable <= sync_out;
        count  <= '0;
      end else if (count != '1) begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rvsteel_gpio_input_irq.sv
// GPIO input conditioning bank: per-pin debounce plus edge-triggered interrupt
// with write-one-to-clear pending latch, on the rvsteel request/response bus.
module rvsteel_gpio_input_irq
  import rvsteel_gpio_input_irq_pkg::*;
#(
  parameter int GPIO_WIDTH     = 1,
  parameter int DEBOUNCE_WIDTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] rw_address,
  output logic [31:0]               read_data,
  input  logic                      read_request,
  output logic                      read_response,
  input  logic [31:0]               write_data,
  input  logic [3:0]                write_strobe,
  input  logic                      write_request,
  output logic                      write_response,
  input  logic [GPIO_WIDTH-1:0]     pad_input,
  output logic [GPIO_WIDTH-1:0]     gpio_input,
  output logic                      irq
);

  logic [GPIO_WIDTH-1:0]     rise_en;
  logic [GPIO_WIDTH-1:0]     fall_en;
  logic [GPIO_WIDTH-1:0]     pending;
  logic [GPIO_WIDTH-1:0]     level;
  logic [GPIO_WIDTH-1:0]     rise;
  logic [GPIO_WIDTH-1:0]     fall;
  logic [GPIO_WIDTH-1:0]     pending_clear;
  logic [DEBOUNCE_WIDTH-1:0] debounce_threshold;
  logic                      write_valid;
  logic [31:0]               read_word;
  logic                      unused_write_bits;

  assign unused_write_bits = ^write_data;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    rvsteel_gpio_debounce #(
      .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)
    ) u_debounce (
      .clock     (clock),
      .reset     (reset),
      .pad       (pad_input[i]),
      .threshold (debounce_threshold),
      .stable    (level[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

  always_comb begin
    write_valid   = write_request && is_aligned(rw_address) && is_full_word(write_strobe);
    pending_clear = '0;
    if (write_valid && rw_address == REG_PENDING) begin
      pending_clear = write_data[GPIO_WIDTH-1:0];
    end
  end

  always_comb begin
    read_word = '0;
    if (is_aligned(rw_address)) begin
      case (rw_address)
        REG_RISE_EN:  read_word[GPIO_WIDTH-1:0]     = rise_en;
        REG_FALL_EN:  read_word[GPIO_WIDTH-1:0]     = fall_en;
        REG_PENDING:  read_word[GPIO_WIDTH-1:0]     = pending;
        REG_LEVEL:    read_word[GPIO_WIDTH-1:0]     = level;
        REG_DEBOUNCE: read_word[DEBOUNCE_WIDTH-1:0] = debounce_threshold;
        default:      read_word                     = '0;
      endcase
    end
  end

  // A new edge in the same cycle as a W1C of that bit must not be lost, so set wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      rise_en            <= '0;
      fall_en            <= '0;
      pending            <= '0;
      debounce_threshold <= '0;
    end else begin
      pending <= (pending & ~pending_clear) | (rise & rise_en) | (fall & fall_en);
      if (write_valid && rw_address == REG_RISE_EN) begin
        rise_en <= write_data[GPIO_WIDTH-1:0];
      end
      if (write_valid && rw_address == REG_FALL_EN) begin
        fall_en <= write_data[GPIO_WIDTH-1:0];
      end
      if (write_valid && rw_address == REG_DEBOUNCE) begin
        debounce_threshold <= write_data[DEBOUNCE_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_data      <= '0;
      read_response  <= 1'b0;
      write_response <= 1'b0;
    end else begin
      read_response  <= read_request;
      write_response <= write_request;
      if (read_request) begin
        read_data <= read_word;
      end
    end
  end

  assign gpio_input = level;
  assign irq        = |pending;

endmodule

// File: tb/tb_rvsteel_gpio_input_irq.sv
// Bench for rvsteel_gpio_input_irq: directed scenarios plus a randomized run
// compared against a window-based behavioural model of debounce and interrupts.
module tb_rvsteel_gpio_input_irq;
  import rvsteel_gpio_input_irq_pkg::*;

  localparam int W  = 4;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    rw_address;
  logic [31:0]   read_data;
  logic          read_request;
  logic          read_response;
  logic [31:0]   write_data;
  logic [3:0]    write_strobe;
  logic          write_request;
  logic          write_response;
  logic [W-1:0]  pad_input;
  logic [W-1:0]  gpio_input;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  rvsteel_gpio_input_irq #(
    .GPIO_WIDTH     (W),
    .DEBOUNCE_WIDTH (DW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_request  (write_request),
    .write_response (write_response),
    .pad_input      (pad_input),
    .gpio_input     (gpio_input),
    .irq            (irq)
  );

  // Reference model: a pin's level flips when the synchronised pad (pad two
  // edges ago) has disagreed with it on each of the last N+1 edges.
  logic [W-1:0]  pad_q[$];
  logic [W-1:0]  m_stable   = '0;
  logic [W-1:0]  m_rise_en  = '0;
  logic [W-1:0]  m_fall_en  = '0;
  logic [W-1:0]  m_pending  = '0;
  logic [DW-1:0] m_deb      = '0;
  logic [31:0]   m_read_exp = '0;
  logic          m_rresp    = 1'b0;
  logic          m_wresp    = 1'b0;

  function automatic logic [W-1:0] sync_at(input int back);
    int idx;
    idx = pad_q.size() - 2 - back;
    if (idx < 0) return '0;
    return pad_q[idx];
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      REG_RISE_EN:  v[W-1:0]  = m_rise_en;
      REG_FALL_EN:  v[W-1:0]  = m_fall_en;
      REG_PENDING:  v[W-1:0]  = m_pending;
      REG_LEVEL:    v[W-1:0]  = m_stable;
      REG_DEBOUNCE: v[DW-1:0] = m_deb;
      default:      v         = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic [W-1:0] nxt;
    logic [W-1:0] s;
    logic [W-1:0] clr;
    logic         wv;
    logic         flip;
    if (reset) begin
      m_stable  = '0;
      m_rise_en = '0;
      m_fall_en = '0;
      m_pending = '0;
      m_deb     = '0;
      m_read_exp = '0;
      m_rresp   = 1'b0;
      m_wresp   = 1'b0;
      pad_q.delete();
    end else begin
      m_rresp = read_request;
      m_wresp = write_request;
      if (read_request) m_read_exp = model_read(rw_address);
      nxt = m_stable;
      for (int i = 0; i < W; i++) begin
        flip = 1'b1;
        for (int b = 0; b <= int'(m_deb); b++) begin
          s = sync_at(b);
          if (s[i] == m_stable[i]) flip = 1'b0;
        end
        if (flip) nxt[i] = ~m_stable[i];
      end
      wv  = write_request && (write_strobe == 4'hF);
      clr = (wv && rw_address == REG_PENDING) ? write_data[W-1:0] : '0;
      m_pending = (m_pending & ~clr) | (nxt & ~m_stable & m_rise_en) | (~nxt & m_stable & m_fall_en);
      if (wv && rw_address == REG_RISE_EN)  m_rise_en = write_data[W-1:0];
      if (wv && rw_address == REG_FALL_EN)  m_fall_en = write_data[W-1:0];
      if (wv && rw_address == REG_DEBOUNCE) m_deb     = write_data[DW-1:0];
      m_stable = nxt;
      pad_q.push_back(pad_input);
      if (pad_q.size() > 40) void'(pad_q.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic resp);
    @(negedge clock);
    rw_address    = a;
    write_data    = d;
    write_strobe  = s;
    write_request = 1'b1;
    @(negedge clock);
    write_request = 1'b0;
    resp          = write_response;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic resp);
    @(negedge clock);
    rw_address   = a;
    read_request = 1'b1;
    @(negedge clock);
    read_request = 1'b0;
    d            = read_data;
    resp         = read_response;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        r;
    logic [4:0]  addrs [5];
    addrs = '{REG_RISE_EN, REG_FALL_EN, REG_PENDING, REG_LEVEL, REG_DEBOUNCE};
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (gpio_input !== '0) begin
      failures++;
      $display("[TB] FAIL reset_gpio_input: got %h expected 0", gpio_input);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_irq: got %b expected 0", irq);
    end
    checks++;
    if (read_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_read_data: got %h expected 0", read_data);
    end
    foreach (addrs[i]) begin
      bus_read(addrs[i], d, r);
      checks++;
      if (r !== 1'b1 || d !== 32'h0) begin
        failures++;
        $display("[TB] FAIL reset_read addr=%h: got resp=%b data=%h expected resp=1 data=0",
                 addrs[i], r, d);
      end
    end
  endtask

  task automatic test_debounce();
    logic r;
    logic e;
    bus_write(REG_DEBOUNCE, 32'd3, 4'hF, r);
    checks++;
    if (r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL debounce_write_resp: got %b expected 1", r);
    end
    @(negedge clock);
    pad_input[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      e = (k == 6);
      checks++;
      if (gpio_input[0] !== e) begin
        failures++;
        $display("[TB] FAIL debounce_rise k=%0d: got %b expected %b", k, gpio_input[0], e);
      end
    end
    // 3-cycle low glitch is shorter than N+1 and must vanish
    @(negedge clock);
    pad_input[0] = 1'b0;
    repeat (3) @(negedge clock);
    pad_input[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      checks++;
      if (gpio_input[0] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL debounce_glitch k=%0d: got %b expected 1", k, gpio_input[0]);
      end
    end
    // a 4-cycle pulse (exactly N+1) gets through
    pad_input[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      e = (k < 6);
      checks++;
      if (gpio_input[0] !== e) begin
        failures++;
        $display("[TB] FAIL debounce_min_pulse k=%0d: got %b expected %b", k, gpio_input[0], e);
      end
      if (k == 4) pad_input[0] = 1'b1;
    end
    repeat (6) @(negedge clock);
    checks++;
    if (gpio_input[0] !== 1'b1 || irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL debounce_restore: got level=%b irq=%b expected level=1 irq=0",
               gpio_input[0], irq);
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] d;
    logic        r;
    logic        e;
    @(negedge clock);
    pad_input[0] = 1'b0;
    repeat (8) @(negedge clock);
    bus_write(REG_RISE_EN, 32'h1, 4'hF, r);
    @(negedge clock);
    pad_input[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      e = (k == 6);
      checks++;
      if (irq !== e) begin
        failures++;
        $display("[TB] FAIL rise_irq k=%0d: got %b expected %b", k, irq, e);
      end
    end
    bus_read(REG_PENDING, d, r);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL rise_pending: got %h expected 1", d);
    end
    bus_write(REG_PENDING, 32'h1, 4'hF, r);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rise_w1c_irq: got %b expected 0", irq);
    end
    bus_read(REG_PENDING, d, r);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rise_w1c_pending: got %h expected 0", d);
    end
  endtask

  task automatic test_fall_only();
    logic [31:0] d;
    logic        r;
    bus_write(REG_RISE_EN, 32'h0, 4'hF, r);
    bus_write(REG_FALL_EN, 32'h2, 4'hF, r);
    @(negedge clock);
    pad_input[1] = 1'b1;
    repeat (8) @(negedge clock);
    bus_read(REG_PENDING, d, r);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0 || gpio_input[1] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fall_after_rise: got pending=%h irq=%b level1=%b expected 0 0 1",
               d, irq, gpio_input[1]);
    end
    @(negedge clock);
    pad_input[1] = 1'b0;
    repeat (8) @(negedge clock);
    bus_read(REG_PENDING, d, r);
    checks++;
    if (d !== 32'h2 || irq !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fall_after_fall: got pending=%h irq=%b expected 2 1", d, irq);
    end
    bus_write(REG_FALL_EN, 32'h0, 4'hF, r);
    bus_read(REG_PENDING, d, r);
    checks++;
    if (d !== 32'h2) begin
      failures++;
      $display("[TB] FAIL fall_enable_off_keeps_pending: got %h expected 2", d);
    end
    bus_write(REG_PENDING, 32'h2, 4'hF, r);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fall_w1c_irq: got %b expected 0", irq);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] d;
    logic        r;
    bus_write(REG_RISE_EN, 32'h1, 4'hF, r);
    @(negedge clock);
    pad_input[0] = 1'b0;
    repeat (8) @(negedge clock);
    pad_input[0] = 1'b1;
    repeat (5) @(posedge clock);
    bus_write(REG_PENDING, 32'h1, 4'hF, r);
    checks++;
    if (irq !== 1'b1 || gpio_input[0] !== 1'b1) begin
      failures++;
      $display("[TB] FAIL w1c_race_irq: got irq=%b level0=%b expected 1 1", irq, gpio_input[0]);
    end
    bus_read(REG_PENDING, d, r);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL w1c_race_pending: got %h expected 1", d);
    end
    bus_write(REG_PENDING, 32'h1, 4'hF, r);
  endtask

  task automatic test_bus_illegal();
    logic [31:0] d;
    logic        r;
    bus_write(REG_RISE_EN, 32'hF, 4'b0011, r);
    checks++;
    if (r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL partial_strobe_resp: got %b expected 1", r);
    end
    bus_write(5'h01, 32'hF, 4'hF, r);
    checks++;
    if (r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL misaligned_write_resp: got %b expected 1", r);
    end
    bus_write(REG_LEVEL, 32'hF, 4'hF, r);
    bus_read(REG_RISE_EN, d, r);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL illegal_write_rise_en: got %h expected 1", d);
    end
    bus_read(REG_LEVEL, d, r);
    checks++;
    if (d !== 32'h1) begin
      failures++;
      $display("[TB] FAIL level_readonly: got %h expected 1", d);
    end
    bus_read(5'h14, d, r);
    checks++;
    if (d !== 32'h0 || r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL unmapped_read: got data=%h resp=%b expected 0 1", d, r);
    end
    bus_read(5'h11, d, r);
    checks++;
    if (d !== 32'h0 || r !== 1'b1) begin
      failures++;
      $display("[TB] FAIL misaligned_read: got data=%h resp=%b expected 0 1", d, r);
    end
  endtask

  task automatic test_random();
    logic [4:0] addrs [6];
    logic [4:0] a;
    int         op;
    addrs = '{REG_RISE_EN, REG_FALL_EN, REG_PENDING, REG_LEVEL, REG_DEBOUNCE, 5'h00};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      checks++;
      if (gpio_input !== m_stable) begin
        failures++;
        $display("[TB] FAIL rand_level cyc=%0d: got %h expected %h", cyc, gpio_input, m_stable);
      end
      checks++;
      if (irq !== (|m_pending)) begin
        failures++;
        $display("[TB] FAIL rand_irq cyc=%0d: got %b expected %b", cyc, irq, |m_pending);
      end
      checks++;
      if (read_response !== m_rresp || write_response !== m_wresp) begin
        failures++;
        $display("[TB] FAIL rand_resp cyc=%0d: got r=%b w=%b expected r=%b w=%b",
                 cyc, read_response, write_response, m_rresp, m_wresp);
      end
      if (m_rresp) begin
        checks++;
        if (read_data !== m_read_exp) begin
          failures++;
          $display("[TB] FAIL rand_read cyc=%0d: got %h expected %h", cyc, read_data, m_read_exp);
        end
      end
      read_request  = 1'b0;
      write_request = 1'b0;
      reset         = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 7) == 0) pad_input[i] = ~pad_input[i];
      end
      op = int'($urandom_range(0, 9));
      a  = addrs[$urandom_range(0, 5)];
      if ($urandom_range(0, 4) == 0) a = 5'($urandom_range(0, 31));
      rw_address = a;
      if (op < 2) begin
        read_request = 1'b1;
      end else if (op < 4) begin
        write_request = 1'b1;
        write_data    = $urandom;
        if (a == REG_DEBOUNCE) write_data = 32'($urandom_range(0, 4));
        write_strobe  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      end
    end
    @(negedge clock);
    reset         = 1'b0;
    read_request  = 1'b0;
    write_request = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    rw_address    = '0;
    read_request  = 1'b0;
    write_data    = '0;
    write_strobe  = '0;
    write_request = 1'b0;
    pad_input     = '0;
    test_reset();
    test_debounce();
    test_rise_irq();
    test_fall_only();
    test_w1c_race();
    test_bus_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
